decode: RTL and testbench

Decode stage of the five-stage pipelined MIPS core, directly downstream of `fetch`. Contains the IF/ID pipeline register that captures `instrF`/`pcplus4F`, the 32×32 register file, sign extension, and early branch/jump resolution. The branch and jump targets and the `pcsrcD`/`jumpD` selects go back to the PC mux in front of `fetch`.

---
 rtl/decode.sv | 125 ++++++++++++
 tb/tb_decode.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode.sv
// MIPS decode stage: IF/ID register, 32x32 register file,
// sign extension and early branch/jump resolution.
//
// Ports:
//   clk, reset        pipeline clock, async active-low reset
//   stallD, flushD    IF/ID hold / bubble from the hazard unit
//   instrF, pcplus4F  fetch-stage instruction and PC+4
//   regwriteW,
//   writeregW,
//   resultW           writeback port (written on falling clk)
//   forwardAD/BD,
//   aluoutM           branch-compare forwarding from memory stage
//   instrD, pcplus4D  registered IF/ID contents
//   rd1D, rd2D        register file read data (rs, rt)
//   rsD, rtD, rdD     register specifier fields
//   signimmD          sign-extended immediate
//   pcbranchD,
//   pcjumpD           branch and jump targets
//   pcsrcD, jumpD     PC mux selects
module decode (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallD,
  input  logic        flushD,
  input  logic [31:0] instrF,
  input  logic [31:0] pcplus4F,
  input  logic        regwriteW,
  input  logic [4:0]  writeregW,
  input  logic [31:0] resultW,
  input  logic        forwardAD,
  input  logic        forwardBD,
  input  logic [31:0] aluoutM,
  output logic [31:0] instrD,
  output logic [31:0] pcplus4D,
  output logic [31:0] rd1D,
  output logic [31:0] rd2D,
  output logic [4:0]  rsD,
  output logic [4:0]  rtD,
  output logic [4:0]  rdD,
  output logic [31:0] signimmD,
  output logic [31:0] pcbranchD,
  output logic [31:0] pcjumpD,
  output logic        pcsrcD,
  output logic        jumpD
);

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  logic [31:0] r_instr;
  logic [31:0] r_pcplus4;
  logic [31:0] r_rf [32];

  logic [5:0]  w_op;
  logic [31:0] w_eqa;
  logic [31:0] w_eqb;
  logic        w_eq;
  logic        w_is_beq;
  logic        w_is_bne;

  // IF/ID register: reset > stall > flush > load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr   <= '0;
      r_pcplus4 <= '0;
    end else if (stallD) begin
      r_instr   <= r_instr;
      r_pcplus4 <= r_pcplus4;
    end else if (flushD) begin
      r_instr   <= '0;
      r_pcplus4 <= '0;
    end else begin
      r_instr   <= instrF;
      r_pcplus4 <= pcplus4F;
    end
  end

  assign instrD   = r_instr;
  assign pcplus4D = r_pcplus4;

  // Falling-edge write lets the same cycle's reads see
  // the writeback value without a bypass path.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        r_rf[i] <= '0;
      end
    end else if (regwriteW && (writeregW != 5'd0)) begin
      r_rf[writeregW] <= resultW;
    end
  end

  assign w_op = r_instr[31:26];
  assign rsD  = r_instr[25:21];
  assign rtD  = r_instr[20:16];
  assign rdD  = r_instr[15:11];

  // $0 is hardwired; entry 0 is never written but is
  // masked anyway so the read is zero by construction.
  assign rd1D = (rsD == 5'd0) ? 32'd0 : r_rf[rsD];
  assign rd2D = (rtD == 5'd0) ? 32'd0 : r_rf[rtD];

  assign signimmD  = {{16{r_instr[15]}}, r_instr[15:0]};
  assign pcbranchD = {signimmD[29:0], 2'b00} + r_pcplus4;
  assign pcjumpD   = {r_pcplus4[31:28], r_instr[25:0], 2'b00};

  assign jumpD = (w_op == OP_J);

  assign w_eqa    = forwardAD ? aluoutM : rd1D;
  assign w_eqb    = forwardBD ? aluoutM : rd2D;
  assign w_eq     = (w_eqa == w_eqb);
  assign w_is_beq = (w_op == OP_BEQ);
  assign w_is_bne = (w_op == OP_BNE);

  always_comb begin
    pcsrcD = 1'b0;
    unique case (1'b1)
      w_is_beq: pcsrcD = w_eq;
      w_is_bne: pcsrcD = !w_eq;
      default:  pcsrcD = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: vector table for branch/jump
// decode plus sequences for reset, stall/flush and regfile.
module tb_decode;

  logic        clk;
  logic        reset;
  logic        stallD;
  logic        flushD;
  logic [31:0] instrF;
  logic [31:0] pcplus4F;
  logic        regwriteW;
  logic [4:0]  writeregW;
  logic [31:0] resultW;
  logic        forwardAD;
  logic        forwardBD;
  logic [31:0] aluoutM;
  logic [31:0] instrD;
  logic [31:0] pcplus4D;
  logic [31:0] rd1D;
  logic [31:0] rd2D;
  logic [4:0]  rsD;
  logic [4:0]  rtD;
  logic [4:0]  rdD;
  logic [31:0] signimmD;
  logic [31:0] pcbranchD;
  logic [31:0] pcjumpD;
  logic        pcsrcD;
  logic        jumpD;

  int errors = 0;
  int checks = 0;

  decode dut (
    .clk(clk), .reset(reset),
    .stallD(stallD), .flushD(flushD),
    .instrF(instrF), .pcplus4F(pcplus4F),
    .regwriteW(regwriteW), .writeregW(writeregW),
    .resultW(resultW),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .aluoutM(aluoutM),
    .instrD(instrD), .pcplus4D(pcplus4D),
    .rd1D(rd1D), .rd2D(rd2D),
    .rsD(rsD), .rtD(rtD), .rdD(rdD),
    .signimmD(signimmD),
    .pcbranchD(pcbranchD), .pcjumpD(pcjumpD),
    .pcsrcD(pcsrcD), .jumpD(jumpD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fa;
    logic        fb;
    logic [31:0] alu;
    logic        e_pcsrc;
    logic        e_jump;
    logic [31:0] e_br;
    logic [31:0] e_jt;
    logic [31:0] e_imm;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic [4:0]  e_rd;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h",
               name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] r,
                    input logic [31:0] v);
    regwriteW = 1'b1;
    writeregW = r;
    resultW   = v;
    @(negedge clk);
    #1;
    regwriteW = 1'b0;
  endtask

  task automatic load(input logic [31:0] ins,
                      input logic [31:0] pc);
    instrF   = ins;
    pcplus4F = pc;
    step();
  endtask

  initial begin
    reset = 1'b0; stallD = 1'b0; flushD = 1'b0;
    instrF = 32'h8C08_0004; pcplus4F = 32'h40;
    regwriteW = 1'b0; writeregW = '0; resultW = '0;
    forwardAD = 1'b0; forwardBD = 1'b0; aluoutM = '0;

    //        instr        pc           fa fb alu
    //        pcsrc jump  br           jt
    //        imm          rd1          rd2       rd
    vecs[0] = '{32'h1109FFFE, 32'h100, 1, 0, 32'd5,
                1, 0, 32'h0F8, 32'h0427FFF8,
                32'hFFFFFFFE, 32'hDEADBEEF, 32'd5, 5'd31};
    vecs[1] = '{32'h1109FFFE, 32'h100, 0, 0, 32'd5,
                0, 0, 32'h0F8, 32'h0427FFF8,
                32'hFFFFFFFE, 32'hDEADBEEF, 32'd5, 5'd31};
    vecs[2] = '{32'h152A0004, 32'h200, 0, 0, 32'd0,
                0, 0, 32'h210, 32'h04A80010,
                32'h4, 32'd5, 32'd5, 5'd0};
    vecs[3] = '{32'h15090010, 32'h300, 0, 0, 32'd0,
                1, 0, 32'h340, 32'h04240040,
                32'h10, 32'hDEADBEEF, 32'd5, 5'd0};
    vecs[4] = '{32'h08000040, 32'h10000004, 0, 0, 32'd0,
                0, 1, 32'h10000104, 32'h10000100,
                32'h40, 32'd0, 32'd0, 5'd0};
    vecs[5] = '{32'h8C080004, 32'h20, 0, 0, 32'd0,
                0, 0, 32'h30, 32'h00200010,
                32'h4, 32'd0, 32'hDEADBEEF, 5'd0};
    vecs[6] = '{32'h112A8000, 32'h400, 0, 1, 32'd7,
                0, 0, 32'hFFFE0400, 32'h04AA0000,
                32'hFFFF8000, 32'd5, 32'd5, 5'd16};

    // Reset state, no clock edge yet.
    #2;
    chk("rst_instrD", instrD, 32'd0);
    chk("rst_pcplus4D", pcplus4D, 32'd0);
    chk("rst_pcsrcD", {31'd0, pcsrcD}, 32'd0);
    chk("rst_jumpD", {31'd0, jumpD}, 32'd0);
    chk("rst_pcbranchD", pcbranchD, 32'd0);
    chk("rst_signimmD", signimmD, 32'd0);
    #1;
    reset = 1'b1;

    // Read-after-write in the same cycle on rs=8.
    load(32'h0100_0000, 32'h4);
    chk("raw_before", rd1D, 32'd0);
    wr(5'd8, 32'hDEADBEEF);
    chk("raw_after", rd1D, 32'hDEADBEEF);
    // Write to $0 is dropped; rt=0 reads zero.
    wr(5'd0, 32'h1234_5678);
    chk("r0_rd2D", rd2D, 32'd0);
    wr(5'd9, 32'd5);
    wr(5'd10, 32'd5);

    foreach (vecs[i]) begin
      forwardAD = vecs[i].fa;
      forwardBD = vecs[i].fb;
      aluoutM   = vecs[i].alu;
      load(vecs[i].instr, vecs[i].pc);
      chk($sformatf("v%0d_instrD", i), instrD, vecs[i].instr);
      chk($sformatf("v%0d_pcsrcD", i),
          {31'd0, pcsrcD}, {31'd0, vecs[i].e_pcsrc});
      chk($sformatf("v%0d_jumpD", i),
          {31'd0, jumpD}, {31'd0, vecs[i].e_jump});
      chk($sformatf("v%0d_pcbranchD", i),
          pcbranchD, vecs[i].e_br);
      chk($sformatf("v%0d_pcjumpD", i),
          pcjumpD, vecs[i].e_jt);
      chk($sformatf("v%0d_signimmD", i),
          signimmD, vecs[i].e_imm);
      chk($sformatf("v%0d_rd1D", i), rd1D, vecs[i].e_rd1);
      chk($sformatf("v%0d_rd2D", i), rd2D, vecs[i].e_rd2);
      chk($sformatf("v%0d_rdD", i),
          {27'd0, rdD}, {27'd0, vecs[i].e_rd});
    end
    forwardAD = 1'b0;
    forwardBD = 1'b0;

    // Stall for 5 cycles while fetch keeps changing.
    load(32'h8C08_0004, 32'h24);
    stallD = 1'b1;
    for (int k = 0; k < 5; k++) begin
      load(32'h2000_0000 + k, 32'h100 + 4 * k);
      chk($sformatf("stall%0d_instrD", k),
          instrD, 32'h8C08_0004);
      chk($sformatf("stall%0d_pc", k), pcplus4D, 32'h24);
    end
    flushD = 1'b1;
    load(32'hAAAA_5555, 32'h500);
    chk("stallflush_instrD", instrD, 32'h8C08_0004);
    chk("stallflush_pc", pcplus4D, 32'h24);
    stallD = 1'b0;
    load(32'hBBBB_0000, 32'h600);
    chk("flush_instrD", instrD, 32'd0);
    chk("flush_pc", pcplus4D, 32'd0);
    flushD = 1'b0;

    // Mid-run asynchronous reset.
    forwardAD = 1'b1;
    aluoutM   = 32'd5;
    load(32'h1109FFFE, 32'h100);
    chk("pre_rst_pcsrcD", {31'd0, pcsrcD}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_instrD", instrD, 32'd0);
    chk("mid_rst_pc", pcplus4D, 32'd0);
    chk("mid_rst_pcsrcD", {31'd0, pcsrcD}, 32'd0);
    chk("mid_rst_rd1D", rd1D, 32'd0);
    forwardAD = 1'b0;
    instrF   = 32'h8C08_0004;
    pcplus4F = 32'h8;
    #1;
    reset = 1'b1;
    step();
    chk("post_rst_instrD", instrD, 32'h8C08_0004);
    chk("post_rst_pc", pcplus4D, 32'h8);
    // Register file was cleared: rt=8 now reads 0.
    chk("post_rst_rd2D", rd2D, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
